snake_game_sequencer: RTL and testbench

//  Top-level game controller for the snake game. It paces snake movement with a tick divider
//  and holds the direction register, which filters out reversals. It advances the head

---
 rtl/snake_game_sequencer.sv | 148 ++++++++++++++
 tb/tb_snake_game_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_sequencer.sv
// Snake game controller: paces moves, filters direction reversals, advances the head,
// detects wall/self collisions and counts growth events.
module snake_game_sequencer #(
    parameter int unsigned TICK_DIV = 250000,
    parameter int unsigned X_MAX    = 39,
    parameter int unsigned Y_MAX    = 29,
    parameter int unsigned HEAD_X0  = 5,
    parameter int unsigned HEAD_Y0  = 5,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned MAX_LEN  = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_key_up,
    input  logic       i_key_down,
    input  logic       i_key_left,
    input  logic       i_key_right,
    input  logic       i_add_cube,
    input  logic       i_body_hit,
    output logic [5:0] o_head_x,
    output logic [5:0] o_head_y,
    output logic [1:0] o_dir,
    output logic       o_shift_en,
    output logic [6:0] o_length,
    output logic [1:0] o_game_state
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [5:0] X_WALL = 6'(X_MAX);
    localparam logic [5:0] Y_WALL = 6'(Y_MAX);
    localparam logic [5:0] X_INIT = 6'(HEAD_X0);
    localparam logic [5:0] Y_INIT = 6'(HEAD_Y0);
    localparam logic [6:0] LEN_INIT = 7'(INIT_LEN);
    localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);
    localparam logic [1:0] DIR_UP = 2'd0;
    localparam logic [1:0] DIR_DOWN = 2'd1;
    localparam logic [1:0] DIR_LEFT = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {StIdle, StRun, StMove, StCheck, StDead} state_e;

    state_e          r_state, w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [5:0]      r_head_x, r_head_y, w_head_x_next, w_head_y_next;
    logic [1:0]      r_dir, r_pend_dir, w_key_dir;
    logic [6:0]      r_length;
    logic            r_add_cube_d;
    logic            w_play, w_reload, w_tick_done, w_hit, w_key_any, w_key_ok, w_grow;

    assign w_play      = (r_state == StRun) || (r_state == StMove) || (r_state == StCheck);
    assign w_reload    = i_start && ((r_state == StIdle) || (r_state == StDead));
    assign w_tick_done = (r_cnt == TICK_LAST);
    assign w_hit       = (r_head_x == 6'd0) || (r_head_x >= X_WALL) ||
                         (r_head_y == 6'd0) || (r_head_y >= Y_WALL) || i_body_hit;
    assign w_grow      = i_add_cube && !r_add_cube_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_next = StRun;
            StRun:   if (w_tick_done) w_state_next = StMove;
            StMove:  w_state_next = StCheck;
            StCheck: w_state_next = w_hit ? StDead : StRun;
            StDead:  if (i_start) w_state_next = StRun;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_shift_en = (r_state == StMove);
        case (r_state)
            StIdle:  o_game_state = 2'd0;
            StDead:  o_game_state = 2'd2;
            default: o_game_state = 2'd1;
        endcase
    end

    // Priority select first; a reversal of the committed direction drops the whole request.
    always_comb begin
        w_key_any = i_key_up || i_key_down || i_key_left || i_key_right;
        if (i_key_up)        w_key_dir = DIR_UP;
        else if (i_key_down) w_key_dir = DIR_DOWN;
        else if (i_key_left) w_key_dir = DIR_LEFT;
        else                 w_key_dir = DIR_RIGHT;
        w_key_ok = w_key_any && (w_key_dir != (r_dir ^ 2'd1));
    end

    always_comb begin
        w_head_x_next = r_head_x;
        w_head_y_next = r_head_y;
        case (r_pend_dir)
            DIR_UP:   w_head_y_next = r_head_y - 6'd1;
            DIR_DOWN: w_head_y_next = r_head_y + 6'd1;
            DIR_LEFT: w_head_x_next = r_head_x - 6'd1;
            default:  w_head_x_next = r_head_x + 6'd1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_add_cube_d <= 1'b0;
        end else begin
            r_add_cube_d <= i_add_cube;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || w_reload) begin
            r_head_x   <= X_INIT;
            r_head_y   <= Y_INIT;
            r_dir      <= DIR_RIGHT;
            r_pend_dir <= DIR_RIGHT;
            r_length   <= LEN_INIT;
            r_cnt      <= '0;
        end else begin
            if (r_state == StRun) begin
                r_cnt <= w_tick_done ? '0 : r_cnt + 1'b1;
            end
            if (r_state == StMove) begin
                r_head_x <= w_head_x_next;
                r_head_y <= w_head_y_next;
                r_dir    <= r_pend_dir;
            end
            if (w_play && w_key_ok) begin
                r_pend_dir <= w_key_dir;
            end
            if (w_play && w_grow && (r_length < LEN_MAX)) begin
                r_length <= r_length + 7'd1;
            end
        end
    end

    assign o_head_x = r_head_x;
    assign o_head_y = r_head_y;
    assign o_dir    = r_dir;
    assign o_length = r_length;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Scoreboard bench: a small model pushes the expected head/dir of every move, and a
// monitor pops and compares on the CHECK cycle that follows each shift_en pulse.
module tb_snake_game_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, ku = 1'b0, kd = 1'b0, kl = 1'b0, kr = 1'b0;
    logic       add_cube = 1'b0, body_hit = 1'b0;
    logic [5:0] head_x, head_y;
    logic [1:0] dir, game_state;
    logic       shift_en;
    logic [6:0] length;

    snake_game_sequencer #(.TICK_DIV(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_key_up(ku), .i_key_down(kd),
        .i_key_left(kl), .i_key_right(kr), .i_add_cube(add_cube), .i_body_hit(body_hit),
        .o_head_x(head_x), .o_head_y(head_y), .o_dir(dir), .o_shift_en(shift_en),
        .o_length(length), .o_game_state(game_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    int exp_q[$];
    int n_moves = 0, n_shifts = 0, cyc = 0, last_shift_cyc = -1, prev_shift_cyc = -1;
    logic seen_shift = 1'b0;
    int m_x, m_y, m_dir, m_pend, m_len;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int head_word();
        return int'({dir, head_x, head_y});
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (seen_shift && game_state == 2'd1) begin
            if (exp_q.size() == 0) check_eq("unexpected_move", head_word(), -1);
            else check_eq("move_head", head_word(), exp_q.pop_front());
            n_moves++;
        end
        if (shift_en) begin
            n_shifts++;
            prev_shift_cyc = last_shift_cyc;
            last_shift_cyc = cyc;
        end
        seen_shift = shift_en;
    end

    task automatic model_reset();
        m_x = 5; m_y = 5; m_dir = 3; m_pend = 3; m_len = 3;
    endtask

    task automatic model_key(input bit u, input bit d, input bit l, input bit r);
        int sel;
        if (!(u || d || l || r)) return;
        sel = u ? 0 : d ? 1 : l ? 2 : 3;
        if (sel != (m_dir ^ 1)) m_pend = sel;
    endtask

    task automatic push_moves(input int n);
        for (int i = 0; i < n; i++) begin
            m_dir = m_pend;
            case (m_dir)
                0: m_y--;
                1: m_y++;
                2: m_x--;
                default: m_x++;
            endcase
            exp_q.push_back((m_dir << 12) | (m_x << 6) | m_y);
        end
    endtask

    task automatic wait_moves(input int k);
        int target = n_moves + k;
        int budget = k * 20;
        while (n_moves < target && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        if (n_moves < target) check_eq("move_timeout", n_moves, target);
    endtask

    task automatic key_pulse(input bit u, input bit d, input bit l, input bit r, input bit play);
        @(negedge clk);
        ku = u; kd = d; kl = l; kr = r;
        if (play) model_key(u, d, l, r);
        @(negedge clk);
        ku = 0; kd = 0; kl = 0; kr = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
    endtask

    task automatic check_home(input string tag, input int gs);
        check_eq({tag, "_state"}, int'(game_state), gs);
        check_eq({tag, "_head"}, head_word(), (3 << 12) | (5 << 6) | 5);
        check_eq({tag, "_len"}, int'(length), 3);
    endtask

    initial begin
        int snap;
        // Reset and idle behaviour
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_home("reset", 0);
        check_eq("reset_shift", int'(shift_en), 0);
        key_pulse(1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("idle_key_dir", int'(dir), 3);
        check_eq("idle_shift", n_shifts, 0);

        // Free running moves
        pulse_start();
        model_reset();
        check_eq("start_state", int'(game_state), 1);
        push_moves(2);
        wait_moves(2);
        check_eq("move_period", last_shift_cyc - prev_shift_cyc, 6);

        // Reversal ignored, then simultaneous keys
        key_pulse(0, 0, 1, 0, 1);
        push_moves(1);
        wait_moves(1);
        key_pulse(1, 0, 1, 0, 1);
        push_moves(1);
        wait_moves(1);

        // Top wall death, frozen while dead, restart
        push_moves(4);
        wait_moves(4);
        @(negedge clk); #1;
        check_eq("top_dead_state", int'(game_state), 2);
        snap = n_shifts;
        key_pulse(0, 0, 1, 0, 0);
        repeat (100) @(negedge clk);
        #1;
        check_eq("dead_head", head_word(), (0 << 12) | (8 << 6) | 0);
        check_eq("dead_no_shift", n_shifts, snap);
        check_eq("dead_state", int'(game_state), 2);
        pulse_start();
        model_reset();
        check_home("restart", 1);

        // Held add_cube grows once; snake then runs into the right wall
        push_moves(34);
        @(negedge clk); add_cube = 1'b1; m_len = 4;
        repeat (60) @(negedge clk);
        #1;
        check_eq("hold_len_play", int'(length), m_len);
        repeat (940) @(negedge clk);
        add_cube = 1'b0;
        #1;
        check_eq("hold_len_end", int'(length), m_len);
        check_eq("right_wall_state", int'(game_state), 2);
        check_eq("queue_drained", exp_q.size(), 0);

        // Toggled growth saturates
        pulse_start();
        model_reset();
        push_moves(34);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk); add_cube = 1'b1;
            @(negedge clk); add_cube = 1'b0;
            if (m_len < 64) m_len++;
        end
        #1;
        check_eq("sat_len", int'(length), m_len);

        // Reset during MOVE
        snap = 0;
        do begin
            @(negedge clk);
            snap++;
        end while (!shift_en && snap < 20);
        check_eq("find_move", int'(shift_en), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_home("move_reset", 0);
        check_eq("move_reset_shift", int'(shift_en), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        check_eq("post_reset_idle", int'(game_state), 0);

        // body_hit ignored in RUN, fatal in CHECK
        pulse_start();
        model_reset();
        push_moves(15);
        wait_moves(15);
        @(negedge clk);
        kd = 1'b1; body_hit = 1'b1; model_key(0, 1, 0, 0);
        @(negedge clk);
        kd = 1'b0;
        @(negedge clk);
        body_hit = 1'b0;
        push_moves(4);
        wait_moves(4);
        check_eq("run_hit_alive", int'(game_state), 1);
        @(negedge clk);
        body_hit = 1'b1;
        push_moves(1);
        wait_moves(1);
        @(negedge clk); #1;
        check_eq("body_dead_state", int'(game_state), 2);
        check_eq("body_dead_head", head_word(), (1 << 12) | (20 << 6) | 10);
        body_hit = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
